// File: rtl/matrix_spi_streamer.sv
// Read-side consumer of the double-buffered matrix frame store.
// Walks the frame address space one byte at a time, captures one byte per
// lane and shifts all lanes out as parallel SPI mode-0 streams sharing one
// SCK and one CS. A trigger arriving mid-frame is remembered (collapsed to a
// single pending request) and served right after the current frame.
module matrix_spi_streamer #(
  parameter int unsigned LANES           = 12,
  parameter int unsigned ADDRESS_NUMBER  = 2250,
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned CS_SETUP_CYCLES = 2,
  localparam int unsigned AW = (ADDRESS_NUMBER > 1) ? $clog2(ADDRESS_NUMBER) : 1
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_buffer_updated,
  input  logic               I_data_valid,
  output logic               O_read_enable,
  output logic [AW-1:0]      O_read_address,
  input  logic [LANES*8-1:0] I_data_flat,
  output logic               O_spi_sck,
  output logic               O_spi_cs_n,
  output logic [LANES-1:0]   O_spi_mosi,
  output logic               O_busy,
  output logic               O_frame_done
);

  // One shared counter times CS setup/hold, read latency and SCK phases.
  localparam int unsigned MaxA   = (CS_SETUP_CYCLES > READ_LATENCY) ? CS_SETUP_CYCLES
                                                                    : READ_LATENCY;
  localparam int unsigned MaxCnt = (MaxA > CLK_DIV) ? MaxA : CLK_DIV;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] LatLast   = CntW'(READ_LATENCY - 1);
  localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
  localparam logic [AW-1:0]   AddrLast  = AW'(ADDRESS_NUMBER - 1);

  // StDone is the single cycle with CS released and frame_done high.
  typedef enum logic [2:0] {
    StIdle, StCsSetup, StFetch, StWait, StShift, StCsHold, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    phase_q, phase_d;   // 0: SCK low half, 1: SCK high half
  logic [2:0]              bit_q, bit_d;
  logic [LANES-1:0][7:0]   shreg_q, shreg_d;
  logic                    pending_q, pending_d;
  logic                    cs_n_q, cs_n_d;
  logic                    sck_q, sck_d;
  logic                    re_q, re_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    trig;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    trig      = I_buffer_updated & I_data_valid;
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    pending_d = pending_q | (trig & (state_q != StIdle));

    case (state_q)
      StIdle: begin
        if (trig || pending_q) begin
          state_d   = StCsSetup;
          cnt_d     = '0;
          addr_d    = '0;
          pending_d = 1'b0;
        end
      end
      StCsSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StFetch;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFetch: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (cnt_q == LatLast) begin
          state_d = StShift;
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          shreg_d = I_data_flat;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Falling SCK: advance every lane to its next bit.
            phase_d = 1'b0;
            for (int i = 0; i < LANES; i++) begin
              shreg_d[i] = {shreg_q[i][6:0], 1'b0};
            end
            if (bit_q == 3'd7) begin
              if (addr_q == AddrLast) begin
                state_d = StCsHold;
              end else begin
                state_d = StFetch;
                addr_d  = addr_q + AW'(1);
              end
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCsHold: begin
        if (cnt_q == SetupLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (pending_q) begin
          state_d   = StCsSetup;
          cnt_d     = '0;
          addr_d    = '0;
          pending_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cs_n_d = (state_d == StIdle) || (state_d == StDone);
    busy_d = (state_d != StIdle);
    re_d   = (state_d == StFetch);
    sck_d  = (state_d == StShift) && phase_d;
    done_d = (state_d == StDone);
  end

  // State and output registers; async reset returns everything to idle.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      phase_q   <= 1'b0;
      bit_q     <= '0;
      shreg_q   <= '0;
      pending_q <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      pending_q <= pending_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      re_q      <= re_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // MOSI is the MSB of each lane's shift register.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      O_spi_mosi[i] = shreg_q[i][7];
    end
  end

  assign O_read_enable  = re_q;
  assign O_read_address = addr_q;
  assign O_spi_sck      = sck_q;
  assign O_spi_cs_n     = cs_n_q;
  assign O_busy         = busy_q;
  assign O_frame_done   = done_q;

endmodule

// File: tb/tb_matrix_spi_streamer.sv
// Bench for matrix_spi_streamer: three instances with different parameter
// sets, a latency-accurate buffer model per instance, and a scoreboard of
// expected {lane1,lane0} bytes consumed by an SPI-level monitor.
module tb_matrix_spi_streamer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  bu = '0;
  logic [2:0]  dv = '0;
  logic [15:0] df [3];
  wire  [2:0]  re, sck, csn, busy, done;
  wire  [1:0]  mosi [3];
  wire  [1:0]  ra0, ra1;
  wire  [0:0]  ra2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] mem [3][4];
  logic [15:0] exp_q [3][$];

  bit  hist_re [3][4];
  int  hist_ad [3][4];

  logic       prev_cs [3];
  logic       prev_sck [3];
  logic [1:0] prev_mo [3];
  logic [7:0] acc0 [3];
  logic [7:0] acc1 [3];
  int lo_cs [3], hi_cs [3], hi_run [3], rises [3], bitn [3], nbyte [3];
  int exp_addr [3], byte_start [3], frames_seen [3], frames_exp [3];
  bit b2b [3];

  matrix_spi_streamer #(.LANES(2), .ADDRESS_NUMBER(4), .READ_LATENCY(2), .CLK_DIV(1),
                        .CS_SETUP_CYCLES(2)) u_dut0 (
    .I_clk(clk), .I_rst(rst), .I_buffer_updated(bu[0]), .I_data_valid(dv[0]),
    .O_read_enable(re[0]), .O_read_address(ra0), .I_data_flat(df[0]),
    .O_spi_sck(sck[0]), .O_spi_cs_n(csn[0]), .O_spi_mosi(mosi[0]),
    .O_busy(busy[0]), .O_frame_done(done[0]));

  matrix_spi_streamer #(.LANES(2), .ADDRESS_NUMBER(4), .READ_LATENCY(1), .CLK_DIV(3),
                        .CS_SETUP_CYCLES(2)) u_dut1 (
    .I_clk(clk), .I_rst(rst), .I_buffer_updated(bu[1]), .I_data_valid(dv[1]),
    .O_read_enable(re[1]), .O_read_address(ra1), .I_data_flat(df[1]),
    .O_spi_sck(sck[1]), .O_spi_cs_n(csn[1]), .O_spi_mosi(mosi[1]),
    .O_busy(busy[1]), .O_frame_done(done[1]));

  matrix_spi_streamer #(.LANES(2), .ADDRESS_NUMBER(1), .READ_LATENCY(2), .CLK_DIV(1),
                        .CS_SETUP_CYCLES(2)) u_dut2 (
    .I_clk(clk), .I_rst(rst), .I_buffer_updated(bu[2]), .I_data_valid(dv[2]),
    .O_read_enable(re[2]), .O_read_address(ra2), .I_data_flat(df[2]),
    .O_spi_sck(sck[2]), .O_spi_cs_n(csn[2]), .O_spi_mosi(mosi[2]),
    .O_busy(busy[2]), .O_frame_done(done[2]));

  function automatic int an_of(input int d);
    return (d == 2) ? 1 : 4;
  endfunction
  function automatic int rl_of(input int d);
    return (d == 1) ? 1 : 2;
  endfunction
  function automatic int cd_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction
  function automatic int bper_of(input int d);
    return 1 + rl_of(d) + 16 * cd_of(d);
  endfunction
  function automatic int flen_of(input int d);
    return 2 * 2 + an_of(d) * bper_of(d);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Buffer model: data for a strobe in cycle F is presented in cycle F+latency,
  // with random garbage whenever no read is due.
  task automatic buf_step(input int d, input logic rev, input int ad);
    int l;
    l = rl_of(d);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        hist_re[d][k] = 1'b0;
        hist_ad[d][k] = 0;
      end
      df[d] = 16'h0;
      return;
    end
    for (int k = 3; k > 0; k--) begin
      hist_re[d][k] = hist_re[d][k-1];
      hist_ad[d][k] = hist_ad[d][k-1];
    end
    hist_re[d][0] = rev;
    hist_ad[d][0] = ad;
    df[d] = hist_re[d][l] ? mem[d][hist_ad[d][l]] : 16'($urandom);
  endtask

  // SPI-level monitor: decodes bytes on SCK rising edges, checks framing.
  task automatic mon_step(input int d, input logic csv, input logic sckv,
                          input logic [1:0] mo, input logic rev, input int ad,
                          input logic dn);
    logic cs_rise, cs_fall, sck_rise, sck_fall;
    if (rst) begin
      prev_cs[d] = 1'b1; prev_sck[d] = 1'b0; prev_mo[d] = 2'b00;
      lo_cs[d] = 0; hi_cs[d] = 0; hi_run[d] = 0; rises[d] = 0; bitn[d] = 0;
      nbyte[d] = 0; exp_addr[d] = 0; acc0[d] = 8'h0; acc1[d] = 8'h0;
      return;
    end
    cs_rise  = !prev_cs[d] && csv;
    cs_fall  = prev_cs[d] && !csv;
    sck_rise = !prev_sck[d] && sckv;
    sck_fall = prev_sck[d] && !sckv;

    if (rev) begin
      chk("re_inside_frame", csv, 0);
      chk("re_address", ad, exp_addr[d]);
      exp_addr[d]++;
    end
    if (dn || cs_rise) chk("frame_done_on_cs_rise", {dn, cs_rise}, 2'b11);

    if (cs_fall) begin
      if (b2b[d]) begin
        chk("cs_gap_between_frames", hi_cs[d], 1);
        b2b[d] = 1'b0;
      end
      hi_cs[d] = 0; rises[d] = 0; bitn[d] = 0; nbyte[d] = 0;
      if (!rev) exp_addr[d] = 0;
    end
    if (!csv) lo_cs[d]++;
    else      hi_cs[d]++;

    if (cs_rise) begin
      chk("cs_low_cycles", lo_cs[d], flen_of(d));
      chk("sck_rising_edges", rises[d], 8 * an_of(d));
      chk("addresses_strobed", exp_addr[d], an_of(d));
      lo_cs[d] = 0;
      frames_seen[d]++;
    end

    if (sck_rise) begin
      chk("sck_inside_frame", csv, 0);
      rises[d]++;
      if (bitn[d] == 0) begin
        if (nbyte[d] > 0) chk("byte_period", cyc - byte_start[d], bper_of(d));
        byte_start[d] = cyc;
      end
      acc0[d] = {acc0[d][6:0], mo[0]};
      acc1[d] = {acc1[d][6:0], mo[1]};
      bitn[d]++;
      if (bitn[d] == 8) begin
        if (exp_q[d].size() == 0) begin
          chk("unexpected_byte", {acc1[d], acc0[d]}, -1);
        end else begin
          chk("lane_bytes", {acc1[d], acc0[d]}, exp_q[d].pop_front());
        end
        bitn[d] = 0;
        nbyte[d]++;
      end
    end
    if (sck_fall) chk("sck_high_cycles", hi_run[d], cd_of(d));
    hi_run[d] = sckv ? hi_run[d] + 1 : 0;

    if (mo !== prev_mo[d]) chk("mosi_changes_with_sck_low", sckv, 0);

    prev_cs[d] = csv; prev_sck[d] = sckv; prev_mo[d] = mo;
  endtask

  // All reference-side sampling happens on the falling edge.
  always @(negedge clk) begin
    cyc++;
    buf_step(0, re[0], int'(ra0));
    buf_step(1, re[1], int'(ra1));
    buf_step(2, re[2], int'(ra2));
    mon_step(0, csn[0], sck[0], mosi[0], re[0], int'(ra0), done[0]);
    mon_step(1, csn[1], sck[1], mosi[1], re[1], int'(ra1), done[1]);
    mon_step(2, csn[2], sck[2], mosi[2], re[2], int'(ra2), done[2]);
  end

  task automatic rand_mem(input int d);
    for (int a = 0; a < 4; a++) mem[d][a] = 16'($urandom);
  endtask

  task automatic trigger(input int d, input bit push);
    if (push) begin
      for (int a = 0; a < an_of(d); a++) exp_q[d].push_back(mem[d][a]);
    end
    @(negedge clk);
    bu[d] = 1'b1;
    @(negedge clk);
    bu[d] = 1'b0;
  endtask

  task automatic wait_frames(input int d);
    int budget;
    budget = 3000;
    while (frames_seen[d] < frames_exp[d] && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("frames_completed", frames_seen[d], frames_exp[d]);
  endtask

  task automatic wait_idle(input int d);
    int budget;
    budget = 3000;
    while (busy[d] && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("returns_idle", busy[d], 0);
  endtask

  task automatic watch_quiet(input int d, input int n, input string nm);
    int act;
    act = 0;
    repeat (n) begin
      @(negedge clk);
      if (csn[d] !== 1'b1 || sck[d] || re[d] || busy[d] || done[d]) act++;
    end
    chk(nm, act, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_cs_n", csn[d], 1);
      chk("reset_sck_busy_re_done", {sck[d], busy[d], re[d], done[d]}, 0);
      chk("reset_mosi", mosi[d], 0);
    end
    dv = 3'b111;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset asserted asynchronously while DUT0 is shifting.
    for (int a = 0; a < 4; a++) mem[0][a] = {8'hA0 + 8'(a), 8'h50 + 8'(a)};
    trigger(0, 1'b1);
    n = 0;
    while (!sck[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_shift", sck[0], 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_cs_n", csn[0], 1);
    chk("async_reset_sck", sck[0], 0);
    chk("async_reset_mosi", mosi[0], 0);
    chk("async_reset_busy", busy[0], 0);
    exp_q[0].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch_quiet(0, 40, "quiet_after_reset");

    // Single frame with the fixed lane pattern.
    trigger(0, 1'b1);
    frames_exp[0]++;
    wait_frames(0);
    wait_idle(0);

    // Trigger while data_valid is low is ignored.
    dv[0] = 1'b0;
    trigger(0, 1'b0);
    watch_quiet(0, 30, "ignored_without_valid");
    dv[0] = 1'b1;

    // Two extra triggers during a frame collapse into one follow-up frame;
    // data_valid dropping mid-frame does not abort anything.
    rand_mem(0);
    trigger(0, 1'b1);
    repeat ($urandom_range(5, 30)) @(negedge clk);
    b2b[0] = 1'b1;
    trigger(0, 1'b1);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    trigger(0, 1'b0);
    dv[0] = 1'b0;
    frames_exp[0] += 2;
    wait_frames(0);
    wait_idle(0);
    dv[0] = 1'b1;
    watch_quiet(0, 100, "no_third_frame");
    chk("frame_count_dut0", frames_seen[0], frames_exp[0]);

    // Random frames on the slow-SCK instance and the single-address instance.
    for (int i = 0; i < 3; i++) begin
      for (int d = 1; d < 3; d++) begin
        rand_mem(d);
        trigger(d, 1'b1);
        frames_exp[d]++;
      end
      wait_frames(1);
      wait_frames(2);
      wait_idle(1);
      wait_idle(2);
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end

    // Back-to-back frames on the single-address instance.
    rand_mem(2);
    trigger(2, 1'b1);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    b2b[2] = 1'b1;
    trigger(2, 1'b1);
    @(negedge clk);
    trigger(2, 1'b0);
    frames_exp[2] += 2;
    wait_frames(2);
    wait_idle(2);
    watch_quiet(2, 40, "no_extra_frame_dut2");

    for (int d = 0; d < 3; d++) begin
      chk("scoreboard_empty", exp_q[d].size(), 0);
      chk("frame_total", frames_seen[d], frames_exp[d]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_spi_streamer.md
Name: matrix_spi_streamer

Overview:
- Read-side consumer of the double-buffered matrix frame store.
- On each buffer-swap pulse it walks the read address space byte by byte and captures one byte per lane.
- Shifts all lanes out in parallel as SPI mode-0 streams (shared SCK/CS, one MOSI per lane) to the ch32v003 matrix controllers.
- Fixed one-byte-per-fetch pipeline: fetch, wait for read latency, shift 8 bits, repeat.

Parameters:
- LANES, 12, number of parallel SPI lanes (BANK_COUNT*BLOCK_COUNT); one byte per lane per address.
- ADDRESS_NUMBER, 2250, bytes per lane per frame; address width is $clog2(ADDRESS_NUMBER).
- READ_LATENCY, 2, cycles from read-enable cycle to valid I_data_flat (buffer plus output register); must be ≥1.
- CLK_DIV, 4, clk cycles per SCK half-period; must be ≥1.
- CS_SETUP_CYCLES, 2, cycles from CS low to first fetch; also CS hold after last bit; must be ≥1.

Ports:
- I_clk  input  1  single clock; all logic on rising edge.
- I_rst  input  1  asynchronous, active-high reset.
- I_buffer_updated  input  1  one-cycle pulse: a new frame is readable.
- I_data_valid  input  1  buffer holds a complete frame; triggers ignored while low.
- O_read_enable  output  1  read strobe to the buffer.
- O_read_address  output  $clog2(ADDRESS_NUMBER)  common read address.
- I_data_flat  input  LANES*8  read data; lane i is bits [i*8 +: 8].
- O_spi_sck  output  1  shared SPI clock, idle low.
- O_spi_cs_n  output  1  shared chip select, active low, framing the whole frame.
- O_spi_mosi  output  LANES  per-lane serial data, MSB first.
- O_busy  output  1  high from trigger acceptance until return to IDLE.
- O_frame_done  output  1  one-cycle pulse when CS deasserts after a frame.

Behaviour:
- Reset (async, immediate, also mid-frame):
  - All outputs 0, except O_spi_cs_n=1.
  - State IDLE, address and pending flag cleared, shift registers 0.
- States: IDLE, CS_SETUP, FETCH, WAIT, SHIFT, CS_HOLD.
- IDLE:
  - Trigger = I_buffer_updated & I_data_valid, or a set pending flag.
  - On trigger: next cycle enter CS_SETUP with O_spi_cs_n=0, O_busy=1, address=0.
- CS_SETUP: stay CS_SETUP_CYCLES cycles, SCK low, then go to FETCH.
- FETCH (1 cycle): O_read_enable=1, O_read_address=current address, then go to WAIT.
- WAIT: READ_LATENCY cycles. On the edge ending the last WAIT cycle, load each lane byte into its shift register, then go to SHIFT.
- SHIFT: 8 bits; each bit is CLK_DIV cycles SCK low followed by CLK_DIV cycles SCK high.
  - O_spi_mosi[i] = bit 7 of lane i's shift register, stable through each full bit period.
  - Shift left on the falling SCK transition between bits.
  - After bit 0's high phase, SCK returns low and:
    - address == ADDRESS_NUMBER-1: go to CS_HOLD.
    - otherwise: address+1, go to FETCH.
- Timing: per byte = 1 + READ_LATENCY + 16*CLK_DIV cycles. SCK stays low during FETCH/WAIT; CS stays low all frame.
- CS_HOLD:
  - CS_SETUP_CYCLES cycles with CS low.
  - Then O_spi_cs_n=1 and O_frame_done=1 for exactly that one cycle.
  - Go to CS_SETUP if the pending flag is set (clear it), else IDLE with O_busy=0.
- Overlap: a trigger while O_busy=1 sets the pending flag. Multiple such triggers collapse into one. The in-progress frame is never restarted or truncated.
- O_read_enable is never asserted outside FETCH. The address never exceeds ADDRESS_NUMBER-1 and never wraps mid-frame.
- I_data_valid dropping mid-frame does not abort the frame.

Test Plan (LANES=2, ADDRESS_NUMBER=4, READ_LATENCY=2, CLK_DIV=1, CS_SETUP_CYCLES=2 unless noted):
- Reset mid-SHIFT:
  - Assert I_rst asynchronously -> same instant cs_n=1, sck=0, mosi=0, busy=0.
  - After release, no output activity until a new trigger.
- Single frame, buffer model returns {lane1,lane0} = {8'hA0+addr, 8'h50+addr} at latency 2:
  - cs_n low exactly 80 cycles; 32 SCK rising edges; addresses 0,1,2,3 each strobed once.
  - Lane0 bytes 50,51,52,53 and lane1 bytes A0..A3, MSB first; frame_done pulses once.
- Trigger with I_data_valid=0 -> no activity, busy stays 0.
- Second trigger during frame plus a third during the same frame:
  - Exactly one extra frame follows.
  - cs_n high for exactly 1 cycle between frames (the frame_done cycle).
- CLK_DIV=3, READ_LATENCY=1:
  - Each SCK phase is 3 cycles; per-byte period is 50 cycles.
  - MOSI changes only while SCK is low.
- ADDRESS_NUMBER=1 -> single fetch at address 0, 8 SCK edges, then CS_HOLD and frame_done.
